// File: rtl/prot_unit_axil_cfg_slave_if.sv
// prot_unit_axil_cfg_slave_if: AXI4-Lite bus bundle between config master and protection-unit slave
interface prot_unit_axil_cfg_slave_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;
   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/prot_unit_axil_cfg_slave.sv
// prot_unit_axil_cfg_slave: AXI4-Lite config/status/policy register slave for the protection unit
module prot_unit_axil_cfg_slave #(
   parameter int          ADDR_W       = 8,
   parameter int          NUM_POLICIES = 4,
   parameter logic [31:0] CFG_RST      = '0
) (
   input  logic                        aclk,
   input  logic                        areset,
   prot_unit_axil_cfg_slave_if.slave   s_axi,
   output logic [31:0]                 cfg_o,
   output logic [32*NUM_POLICIES-1:0]  policy_o,
   input  logic                        viol_valid_i,
   input  logic [31:0]                 viol_addr_i
);
   localparam int IW = ADDR_W - 2;
   localparam logic [IW-1:0] IDX_CFG  = IW'(0);
   localparam logic [IW-1:0] IDX_STAT = IW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(2);
   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;
   w_state_t w_state, w_next;
   r_state_t r_state, r_next;
   logic              aw_held, w_held, aw_hs, w_hs, ar_hs, do_wr, wr_ok, rd_ok, st_clr;
   logic [ADDR_W-1:0] awaddr_q;
   logic [31:0]       wdata_q, wd, rd_val, last_addr;
   logic [3:0]        wstrb_q, ws;
   logic [IW-1:0]     widx, ridx;
   logic              sticky, ovf, sticky_n, ovf_n;
   logic [15:0]       cnt, cnt_n;
   logic [31:0]       policy [NUM_POLICIES];
   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b+:8] = s[b] ? d[8*b+:8] : o[8*b+:8];
      return r;
   endfunction
   for (genvar i = 0; i < NUM_POLICIES; i++) begin : g_pol
      assign policy_o[32*i+:32] = policy[i];
   end
   // Handshakes and the effective write beat: held AW/W or whichever arrives live this cycle
   always_comb begin
      s_axi.awready = !areset && w_state == W_IDLE && !aw_held;
      s_axi.wready  = !areset && w_state == W_IDLE && !w_held;
      s_axi.bvalid  = w_state == W_RESP;
      s_axi.arready = !areset && r_state == R_IDLE;
      s_axi.rvalid  = r_state == R_DATA;
      aw_hs = s_axi.awvalid && s_axi.awready;
      w_hs  = s_axi.wvalid && s_axi.wready;
      ar_hs = s_axi.arvalid && s_axi.arready;
      widx  = aw_held ? awaddr_q[ADDR_W-1:2] : s_axi.awaddr[ADDR_W-1:2];
      wd    = w_held ? wdata_q : s_axi.wdata;
      ws    = w_held ? wstrb_q : s_axi.wstrb;
      ridx  = s_axi.araddr[ADDR_W-1:2];
      do_wr = w_state == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs);
      w_next = w_state;
      if (w_state == W_IDLE && do_wr) w_next = W_RESP;
      else if (w_state == W_RESP && s_axi.bready) w_next = W_IDLE;
      r_next = r_state;
      if (r_state == R_IDLE && ar_hs) r_next = R_DATA;
      else if (r_state == R_DATA && s_axi.rready) r_next = R_IDLE;
   end
   // Address decode for both channels; LAST_VIOL_ADDR is readable but not writable
   always_comb begin
      wr_ok  = widx == IDX_CFG || widx == IDX_STAT;
      rd_ok  = 1'b1;
      rd_val = '0;
      for (int k = 0; k < NUM_POLICIES; k++) if (widx == IW'(16 + k)) wr_ok = 1'b1;
      if (ridx == IDX_CFG) rd_val = cfg_o;
      else if (ridx == IDX_STAT) rd_val = {cnt, 14'd0, ovf, sticky};
      else if (ridx == IDX_LAST) rd_val = last_addr;
      else begin
         rd_ok = 1'b0;
         for (int k = 0; k < NUM_POLICIES; k++) if (ridx == IW'(16 + k)) begin
            rd_val = policy[k];
            rd_ok  = 1'b1;
         end
      end
   end
   // Status next state: W1C clear first, then any coincident violation event on top
   always_comb begin
      st_clr   = do_wr && widx == IDX_STAT && ws[0] && |wd[1:0];
      sticky_n = st_clr && wd[0] ? 1'b0 : sticky;
      ovf_n    = st_clr && wd[1] ? 1'b0 : ovf;
      cnt_n    = st_clr ? 16'd0 : cnt;
      if (viol_valid_i) begin
         sticky_n = 1'b1;
         ovf_n    = ovf_n || &cnt_n;
         cnt_n    = &cnt_n ? cnt_n : cnt_n + 16'd1;
      end
   end
   // Write channel: latch AW/W independently, commit on the edge where both are present
   always_ff @(posedge aclk or posedge areset)
      if (areset) begin
         w_state     <= W_IDLE;
         aw_held     <= 1'b0;
         w_held      <= 1'b0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         s_axi.bresp <= 2'b00;
         cfg_o       <= CFG_RST;
         policy      <= '{default: '0};
      end else begin
         w_state <= w_next;
         if (do_wr) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            s_axi.bresp <= wr_ok ? 2'b00 : 2'b10;
            if (widx == IDX_CFG) cfg_o <= merge(cfg_o, wd, ws);
            for (int k = 0; k < NUM_POLICIES; k++) if (widx == IW'(16 + k)) policy[k] <= merge(policy[k], wd, ws);
         end else begin
            if (aw_hs) begin
               aw_held  <= 1'b1;
               awaddr_q <= s_axi.awaddr;
            end
            if (w_hs) begin
               w_held  <= 1'b1;
               wdata_q <= s_axi.wdata;
               wstrb_q <= s_axi.wstrb;
            end
         end
      end
   // Read channel: register data/response on AR accept, hold until rready
   always_ff @(posedge aclk or posedge areset)
      if (areset) begin
         r_state     <= R_IDLE;
         s_axi.rdata <= '0;
         s_axi.rresp <= 2'b00;
      end else begin
         r_state <= r_next;
         if (ar_hs) begin
            s_axi.rdata <= rd_val;
            s_axi.rresp <= rd_ok ? 2'b00 : 2'b10;
         end
      end
   // Violation log: sticky flag, saturating count, last faulting address
   always_ff @(posedge aclk or posedge areset)
      if (areset) begin
         sticky    <= 1'b0;
         ovf       <= 1'b0;
         cnt       <= '0;
         last_addr <= '0;
      end else begin
         sticky <= sticky_n;
         ovf    <= ovf_n;
         cnt    <= cnt_n;
         if (viol_valid_i) last_addr <= viol_addr_i;
      end
endmodule
